taxi_axil_ram_sp: RTL and testbench
===================================

// Module: taxi_axil_ram_sp
// PURPOSE
//  AXI4-Lite RAM built on one single-port byte-enable memory, with parametrised read latency,
//  read/write round-robin arbitration and out-of-window error responses. Successor to the plain
//  AXI-Lite RAM: a slave endpoint for register banks/scratchpads on interconnect leaves where
//  block RAM ports are scarce. Data/strobe widths are taken from the attached interface.
// PARAMETERS
//  ADDR_W          16  byte-address width of the RAM window; depth = 2**(ADDR_W-log2(STRB_W)) words
//  PIPELINE_OUTPUT 0   extra read register stages after the memory (0..4)
//  CHECK_ADDR      1   1: interface address bits above ADDR_W must be zero, else SLVERR
//  RR_ARB          1   1: round-robin read/write arbitration; 0: fixed write priority
// PORTS
//  clk         in   1    clock; all logic on rising edge
//  rst         in   1    synchronous active-high reset
//  s_axil_wr   slv  if   taxi_axil_if.wr_slv: AW/W/B channels, DATA_W/STRB_W/ADDR_W from interface
//  s_axil_rd   slv  if   taxi_axil_if.rd_slv: AR/R channels
// BEHAVIOUR
//  Reset: awready=wready=arready=0, bvalid=0, rvalid=0, bresp=rresp=OKAY, rdata=0, rr state=write-last.
//   Memory contents not reset. Reset mid-transfer drops pending B/R responses; no memory write occurs
//   in the reset cycle.
//  Word index = addr[ADDR_W-1:log2(STRB_W)]; low byte-offset bits ignored.
//  Write request (wreq) = awvalid && wvalid && (!bvalid || bready). AW and W are consumed together:
//   awready and wready rise in the same cycle, never separately.
//  Read request (rreq) = arvalid && pipe_adv, pipe_adv = !(rvalid && !rready).
//  One memory access per cycle. Both requests: RR_ARB=1 grants opposite of last grant; RR_ARB=0
//   grants write. Losing request sees ready=0 and is granted next cycle (no starvation, RR_ARB=1).
//  Granted write: byte lanes with wstrb set updated at clock edge; bvalid=1 next cycle, held until bready.
//   bresp=OKAY, or SLVERR (2'b10) if CHECK_ADDR and upper addr bits nonzero; erroneous writes change nothing.
//  Granted read: memory output stage + PIPELINE_OUTPUT stages; total latency 1+PIPELINE_OUTPUT cycles from
//   AR handshake to rvalid. All stages advance together only on pipe_adv (whole pipeline stalls under
//   R backpressure; bubbles collapse only when advancing). rdata=0, rresp=SLVERR for out-of-window reads.
//  Back-to-back reads with rready=1: one R beat per cycle sustained.
//  Read of an address written in the same cycle cannot occur (single port). Read granted the cycle after
//   a write returns the new data.
//  wstrb=0: write handshakes and returns OKAY, memory unchanged.
//  Address wrap: in-window addresses never wrap; CHECK_ADDR=0 aliases the window across full space.
//  rdata/rresp held stable while rvalid && !rready; bresp held while bvalid && !bready.
// STRUCTURE
//  taxi_axil_pkg (shared): RESP_OKAY=2'b00, RESP_SLVERR=2'b10 constants.
//  Sub-module taxi_ram_sp_be: single-port RAM, parametrised DATA_W/STRB_W/depth, byte-enable write,
//   registered read; no reset on array or output. Arbiter, B register, read-valid/resp shift
//   pipeline live in this module.
// TESTING
//  Write 0x1234_5678 @0x0010 strb 4'hF, then read 0x0010 -> bresp OKAY, rdata 0x1234_5678 after 1+PIPELINE_OUTPUT cycles.
//  Write 0xAABB_CCDD @0x0020 strb 4'b0101 over 0x0000_0000 -> read returns 0x00BB_00DD.
//  AW/W and AR valid every cycle, RR_ARB=1 -> grants alternate W,R,W,R; RR_ARB=0 -> reads only when no write.
//  CHECK_ADDR=1, write 0xFFFF_FFFF @0x0001_0004 -> bresp SLVERR; read @0x0000_0004 unchanged; read @0x0001_0004 -> SLVERR, rdata 0.
//  PIPELINE_OUTPUT=2, 8 reads with rready toggling 1,0,0,1,... -> data in order, no loss/dup, rdata stable while stalled.
//  Assert rst mid-burst with bvalid=1 and 2 reads in flight -> next cycle all valids/readies 0, no stray R/B afterwards.

Source files
------------

// File: rtl/taxi_axil_pkg.sv
// taxi_axil_pkg: shared AXI-Lite response codes and arbitration state type
package taxi_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {RR_LAST_RD, RR_LAST_WR} rr_state_t;

endpackage

// File: rtl/taxi_axil_if.sv
// taxi_axil_if: AXI4-Lite bundle; widths of attached endpoints come from these parameters
interface taxi_axil_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int STRB_W = DATA_W/8
) ();

    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid, awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid, wready;
    logic [1:0]        bresp;
    logic              bvalid, bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid, arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid, rready;

    modport wr_mst (output awaddr, awprot, awvalid, input awready, output wdata, wstrb, wvalid,
                    input wready, input bresp, bvalid, output bready);
    modport wr_slv (input awaddr, awprot, awvalid, output awready, input wdata, wstrb, wvalid,
                    output wready, output bresp, bvalid, input bready);
    modport rd_mst (output araddr, arprot, arvalid, input arready, input rdata, rresp, rvalid, output rready);
    modport rd_slv (input araddr, arprot, arvalid, output arready, output rdata, rresp, rvalid, input rready);

endinterface

// File: rtl/taxi_ram_sp_be.sv
// taxi_ram_sp_be: single-port RAM with byte-enable write and registered read
module taxi_ram_sp_be #(
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W/8,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              re,
    input  logic [STRB_W-1:0] we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int BYTE_W = DATA_W/STRB_W;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // rdata only moves on re so a stalled read pipeline keeps its head word across writes
    always_ff @(posedge clk) begin
        for (int i = 0; i < STRB_W; i++)
            if (we[i]) mem[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/taxi_axil_ram_sp.sv
// taxi_axil_ram_sp: AXI4-Lite RAM on one single-port memory with read/write arbitration,
// pipelined read path and out-of-window SLVERR responses
module taxi_axil_ram_sp
    import taxi_axil_pkg::*;
#(
    parameter int ADDR_W          = 16,
    parameter int PIPELINE_OUTPUT = 0,
    parameter int CHECK_ADDR      = 1,
    parameter int RR_ARB          = 1
) (
    input  logic        clk,
    input  logic        rst,
    taxi_axil_if.wr_slv s_axil_wr,
    taxi_axil_if.rd_slv s_axil_rd
);

    localparam int DATA_W = s_axil_wr.DATA_W;
    localparam int STRB_W = s_axil_wr.STRB_W;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_W - OFF_W;
    localparam int P      = PIPELINE_OUTPUT;

    rr_state_t         rr_q;
    logic              b_vld;
    logic [1:0]        b_resp;
    logic [P:0]        rd_vld, rd_err;
    logic              pipe_adv, wreq, rreq, grant_w, grant_r, werr, rerr, ram_re;
    logic [IDX_W-1:0]  ram_addr;
    logic [STRB_W-1:0] ram_we;
    logic [DATA_W-1:0] ram_rdata, rd_data;
    logic              unused;

    always_comb begin
        pipe_adv = !(rd_vld[P] && !s_axil_rd.rready);
        wreq     = !rst && s_axil_wr.awvalid && s_axil_wr.wvalid && (!b_vld || s_axil_wr.bready);
        rreq     = !rst && s_axil_rd.arvalid && pipe_adv;
        grant_w  = wreq && (!rreq || RR_ARB == 0 || rr_q == RR_LAST_RD);
        grant_r  = rreq && !grant_w;
        werr     = (CHECK_ADDR != 0) && ((s_axil_wr.awaddr >> ADDR_W) != '0);
        rerr     = (CHECK_ADDR != 0) && ((s_axil_rd.araddr >> ADDR_W) != '0);
        ram_addr = grant_w ? s_axil_wr.awaddr[ADDR_W-1:OFF_W] : s_axil_rd.araddr[ADDR_W-1:OFF_W];
        ram_we   = (grant_w && !werr) ? s_axil_wr.wstrb : '0;
        ram_re   = grant_r && !rerr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q   <= RR_LAST_WR;
            b_vld  <= 1'b0;
            b_resp <= RESP_OKAY;
            rd_vld <= '0;
            rd_err <= '0;
        end else begin
            if (grant_w) rr_q <= RR_LAST_WR;
            else if (grant_r) rr_q <= RR_LAST_RD;
            if (grant_w) begin
                b_vld  <= 1'b1;
                b_resp <= werr ? RESP_SLVERR : RESP_OKAY;
            end else if (s_axil_wr.bready) begin
                b_vld  <= 1'b0;
            end
            if (pipe_adv) begin
                rd_vld[0] <= grant_r;
                rd_err[0] <= grant_r && rerr;
                for (int i = 1; i <= P; i++) begin
                    rd_vld[i] <= rd_vld[i-1];
                    rd_err[i] <= rd_err[i-1];
                end
            end
        end
    end

    generate
        if (P == 0) begin : g_nopipe
            assign rd_data = ram_rdata;
        end else begin : g_pipe
            logic [DATA_W-1:0] pd [P];
            always_ff @(posedge clk) begin
                if (pipe_adv) begin
                    pd[0] <= ram_rdata;
                    for (int i = 1; i < P; i++) pd[i] <= pd[i-1];
                end
            end
            assign rd_data = pd[P-1];
        end
    endgenerate

    taxi_ram_sp_be #(.DATA_W(DATA_W), .STRB_W(STRB_W), .ADDR_W(IDX_W)) u_ram (
        .clk(clk), .re(ram_re), .we(ram_we), .addr(ram_addr),
        .wdata(s_axil_wr.wdata), .rdata(ram_rdata)
    );

    assign s_axil_wr.awready = grant_w;
    assign s_axil_wr.wready  = grant_w;
    assign s_axil_wr.bvalid  = b_vld;
    assign s_axil_wr.bresp   = b_resp;
    assign s_axil_rd.arready = grant_r;
    assign s_axil_rd.rvalid  = rd_vld[P];
    assign s_axil_rd.rresp   = rd_err[P] ? RESP_SLVERR : RESP_OKAY;
    // rdata is forced to zero whenever no valid beat is presented, and for error beats
    assign s_axil_rd.rdata   = (rd_vld[P] && !rd_err[P]) ? rd_data : '0;
    assign unused = ^{s_axil_wr.awprot, s_axil_rd.arprot};

endmodule

// File: tb/tb_taxi_axil_ram_sp.sv
// tb_taxi_axil_ram_sp: directed bench; dut is pipelined/round-robin/checked, dut_b is
// unpipelined/fixed-priority/aliased
module tb_taxi_axil_ram_sp;
    import taxi_axil_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    taxi_axil_if #(.DATA_W(32), .ADDR_W(32)) axa ();
    taxi_axil_if #(.DATA_W(32), .ADDR_W(32)) axb ();

    taxi_axil_ram_sp #(.ADDR_W(16), .PIPELINE_OUTPUT(2), .CHECK_ADDR(1), .RR_ARB(1)) dut (
        .clk(clk), .rst(rst), .s_axil_wr(axa), .s_axil_rd(axa));
    taxi_axil_ram_sp #(.ADDR_W(16), .PIPELINE_OUTPUT(0), .CHECK_ADDR(0), .RR_ARB(0)) dut_b (
        .clk(clk), .rst(rst), .s_axil_wr(axb), .s_axil_rd(axb));

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_all();
        axa.awaddr = '0; axa.awprot = '0; axa.awvalid = 0; axa.wdata = '0; axa.wstrb = '0;
        axa.wvalid = 0; axa.bready = 0; axa.araddr = '0; axa.arprot = '0; axa.arvalid = 0; axa.rready = 0;
        axb.awaddr = '0; axb.awprot = '0; axb.awvalid = 0; axb.wdata = '0; axb.wstrb = '0;
        axb.wvalid = 0; axb.bready = 0; axb.araddr = '0; axb.arprot = '0; axb.arvalid = 0; axb.rready = 0;
    endtask

    task automatic a_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output bit ok);
        ok = 0; resp = 2'bxx;
        axa.awaddr = addr; axa.wdata = data; axa.wstrb = strb;
        axa.awvalid = 1; axa.wvalid = 1; axa.bready = 1;
        for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = axa.awready; end
        @(posedge clk); #1;
        axa.awvalid = 0; axa.wvalid = 0;
        if (!ok) return;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (axa.bvalid) begin ok = 1; resp = axa.bresp; end
        end
        @(posedge clk); #1;
    endtask

    task automatic a_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                          output int lat);
        bit hs = 0;
        lat = -1; data = 'x; resp = 2'bxx;
        axa.araddr = addr; axa.arvalid = 1; axa.rready = 1;
        for (int i = 0; i < 20 && !hs; i++) begin @(negedge clk); hs = axa.arready; end
        @(posedge clk); #1;
        axa.arvalid = 0;
        if (!hs) return;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            @(negedge clk);
            if (axa.rvalid) begin lat = i; data = axa.rdata; resp = axa.rresp; end
        end
        @(posedge clk); #1;
    endtask

    task automatic b_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output bit ok);
        ok = 0; resp = 2'bxx;
        axb.awaddr = addr; axb.wdata = data; axb.wstrb = strb;
        axb.awvalid = 1; axb.wvalid = 1; axb.bready = 1;
        for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = axb.awready; end
        @(posedge clk); #1;
        axb.awvalid = 0; axb.wvalid = 0;
        if (!ok) return;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (axb.bvalid) begin ok = 1; resp = axb.bresp; end
        end
        @(posedge clk); #1;
    endtask

    task automatic b_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                          output int lat);
        bit hs = 0;
        lat = -1; data = 'x; resp = 2'bxx;
        axb.araddr = addr; axb.arvalid = 1; axb.rready = 1;
        for (int i = 0; i < 20 && !hs; i++) begin @(negedge clk); hs = axb.arready; end
        @(posedge clk); #1;
        axb.arvalid = 0;
        if (!hs) return;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            @(negedge clk);
            if (axb.rvalid) begin lat = i; data = axb.rdata; resp = axb.rresp; end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle_all();
        rst = 1;
        axa.awvalid = 1; axa.wvalid = 1; axa.wstrb = 4'hF; axa.arvalid = 1; axa.bready = 1; axa.rready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (axa.awready !== 1'b0 || axa.wready !== 1'b0) begin fails++;
            $display("FAIL reset_wready: got aw=%b w=%b expected 0", axa.awready, axa.wready); end
        checks++; if (axa.arready !== 1'b0) begin fails++;
            $display("FAIL reset_arready: got %b expected 0", axa.arready); end
        checks++; if (axa.bvalid !== 1'b0 || axa.bresp !== RESP_OKAY) begin fails++;
            $display("FAIL reset_b: got bvalid=%b bresp=%b expected 0/00", axa.bvalid, axa.bresp); end
        checks++; if (axa.rvalid !== 1'b0 || axa.rresp !== RESP_OKAY || axa.rdata !== 32'h0) begin fails++;
            $display("FAIL reset_r: got rvalid=%b rresp=%b rdata=%h expected 0/00/0", axa.rvalid, axa.rresp, axa.rdata); end
        checks++; if (axb.rvalid !== 1'b0 || axb.bvalid !== 1'b0 || axb.rdata !== 32'h0) begin fails++;
            $display("FAIL reset_dut_b: got rvalid=%b bvalid=%b rdata=%h expected 0/0/0", axb.rvalid, axb.bvalid, axb.rdata); end
        @(posedge clk); #1;
        idle_all();
        rst = 0;
    endtask

    task automatic test_basic();
        logic [1:0] resp; logic [31:0] d; bit ok; int lat;
        a_write(32'h0000_0010, 32'h1234_5678, 4'hF, resp, ok);
        checks++; if (!ok || resp !== RESP_OKAY) begin fails++;
            $display("FAIL basic_bresp: got ok=%0d bresp=%b expected 1/00", ok, resp); end
        a_read(32'h0000_0010, d, resp, lat);
        checks++; if (lat !== 3) begin fails++;
            $display("FAIL basic_latency: got %0d expected 3", lat); end
        checks++; if (d !== 32'h1234_5678 || resp !== RESP_OKAY) begin fails++;
            $display("FAIL basic_rdata: got %h/%b expected 12345678/00", d, resp); end
    endtask

    task automatic test_strobe();
        logic [1:0] resp; logic [31:0] d; bit ok; int lat;
        a_write(32'h0000_0020, 32'h0000_0000, 4'hF, resp, ok);
        a_write(32'h0000_0020, 32'hAABB_CCDD, 4'b0101, resp, ok);
        a_read(32'h0000_0020, d, resp, lat);
        checks++; if (d !== 32'h00BB_00DD) begin fails++;
            $display("FAIL strobe_partial: got %h expected 00bb00dd", d); end
        a_write(32'h0000_0020, 32'hFFFF_FFFF, 4'h0, resp, ok);
        checks++; if (!ok || resp !== RESP_OKAY) begin fails++;
            $display("FAIL strobe_zero_bresp: got ok=%0d bresp=%b expected 1/00", ok, resp); end
        a_read(32'h0000_0020, d, resp, lat);
        checks++; if (d !== 32'h00BB_00DD) begin fails++;
            $display("FAIL strobe_zero_data: got %h expected 00bb00dd", d); end
    endtask

    task automatic test_addr_check();
        logic [1:0] resp; logic [31:0] d; bit ok; int lat;
        a_write(32'h0000_0004, 32'h1111_2222, 4'hF, resp, ok);
        a_write(32'h0001_0004, 32'hFFFF_FFFF, 4'hF, resp, ok);
        checks++; if (!ok || resp !== RESP_SLVERR) begin fails++;
            $display("FAIL oow_write_bresp: got ok=%0d bresp=%b expected 1/10", ok, resp); end
        a_read(32'h0000_0004, d, resp, lat);
        checks++; if (d !== 32'h1111_2222 || resp !== RESP_OKAY) begin fails++;
            $display("FAIL oow_write_nochange: got %h/%b expected 11112222/00", d, resp); end
        a_read(32'h0001_0004, d, resp, lat);
        checks++; if (d !== 32'h0 || resp !== RESP_SLVERR || lat !== 3) begin fails++;
            $display("FAIL oow_read: got %h/%b lat %0d expected 0/10 lat 3", d, resp, lat); end
        a_write(32'h0000_FFFC, 32'hCAFE_F00D, 4'hF, resp, ok);
        a_read(32'h0000_FFFC, d, resp, lat);
        checks++; if (d !== 32'hCAFE_F00D || resp !== RESP_OKAY) begin fails++;
            $display("FAIL top_of_window: got %h/%b expected cafef00d/00", d, resp); end
    endtask

    task automatic test_round_robin();
        logic [1:0] resp; logic [31:0] d; bit ok; int lat;
        logic [31:0] got [$];
        logic exp_w;
        a_write(32'h0000_0040, 32'hC0DE_00FF, 4'hF, resp, ok);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        for (int k = 0; k < 10; k++) begin
            axa.awaddr = 32'h40; axa.araddr = 32'h40; axa.wdata = 32'hC0DE_0000 + k; axa.wstrb = 4'hF;
            axa.awvalid = (k < 6); axa.wvalid = (k < 6); axa.arvalid = (k < 6);
            axa.bready = 1; axa.rready = 1;
            @(negedge clk);
            if (k < 6) begin
                exp_w = (k % 2 == 1);
                checks++; if (axa.awready !== exp_w || axa.wready !== exp_w || axa.arready !== !exp_w) begin fails++;
                    $display("FAIL rr_grant[%0d]: got aw=%b w=%b ar=%b expected aw=w=%b", k,
                             axa.awready, axa.wready, axa.arready, exp_w); end
            end
            if (axa.rvalid) got.push_back(axa.rdata);
            @(posedge clk); #1;
        end
        checks++; if (got.size() != 3) begin fails++;
            $display("FAIL rr_read_count: got %0d expected 3", got.size()); end
        else begin
            checks++; if (got[0] !== 32'hC0DE_00FF || got[1] !== 32'hC0DE_0001 || got[2] !== 32'hC0DE_0003) begin fails++;
                $display("FAIL rr_read_data: got %h %h %h expected c0de00ff c0de0001 c0de0003", got[0], got[1], got[2]); end
        end
        a_read(32'h0000_0040, d, resp, lat);
        checks++; if (d !== 32'hC0DE_0005) begin fails++;
            $display("FAIL rr_final_word: got %h expected c0de0005", d); end
    endtask

    task automatic test_backpressure();
        logic [1:0] resp; bit ok;
        int issued = 0, got = 0, stab = 0, extra = 0;
        bit held = 0;
        logic [31:0] hd;
        for (int i = 0; i < 8; i++) a_write(32'h100 + 4*i, 32'hA500_0000 + i, 4'hF, resp, ok);
        for (int c = 0; c < 100 && got < 8; c++) begin
            axa.rready = (c % 3 == 0); axa.arvalid = (issued < 8); axa.araddr = 32'h100 + 4*issued;
            @(negedge clk);
            if (axa.arvalid && axa.arready) issued++;
            if (held && (!axa.rvalid || axa.rdata !== hd)) stab++;
            held = 0;
            if (axa.rvalid) begin
                if (axa.rready) begin
                    checks++; if (axa.rdata !== 32'hA500_0000 + got) begin fails++;
                        $display("FAIL bp_beat[%0d]: got %h expected %h", got, axa.rdata, 32'hA500_0000 + got); end
                    got++;
                end else begin
                    held = 1; hd = axa.rdata;
                end
            end
            @(posedge clk); #1;
        end
        axa.arvalid = 0; axa.rready = 1;
        repeat (4) begin @(negedge clk); if (axa.rvalid) extra++; end
        @(posedge clk); #1;
        checks++; if (got != 8 || extra != 0) begin fails++;
            $display("FAIL bp_count: got %0d beats +%0d extra expected 8 +0", got, extra); end
        checks++; if (stab != 0) begin fails++;
            $display("FAIL bp_stable: got %0d unstable stalls expected 0", stab); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] resp; logic [31:0] d; bit ok; int lat;
        int n = 0, stray = 0;
        a_write(32'h0000_0200, 32'h0102_0304, 4'hF, resp, ok);
        axa.bready = 0; axa.awaddr = 32'h300; axa.wdata = 32'h5555_5555; axa.wstrb = 4'hF;
        axa.awvalid = 1; axa.wvalid = 1;
        for (int c = 0; c < 10 && n < 1; c++) begin @(negedge clk); if (axa.awready) n++; @(posedge clk); #1; end
        axa.awvalid = 0; axa.wvalid = 0;
        n = 0; axa.rready = 0; axa.arvalid = 1; axa.araddr = 32'h10;
        for (int c = 0; c < 10 && n < 2; c++) begin @(negedge clk); if (axa.arready) n++; @(posedge clk); #1; end
        axa.arvalid = 0;
        checks++; if (n != 2 || axa.bvalid !== 1'b1 || axa.rvalid !== 1'b0) begin fails++;
            $display("FAIL mid_setup: got reads=%0d bvalid=%b rvalid=%b expected 2/1/0", n, axa.bvalid, axa.rvalid); end
        rst = 1;
        axa.awaddr = 32'h200; axa.wdata = 32'hDEAD_BEEF; axa.awvalid = 1; axa.wvalid = 1; axa.arvalid = 1;
        @(negedge clk);
        checks++; if (axa.awready !== 1'b0 || axa.arready !== 1'b0) begin fails++;
            $display("FAIL mid_rst_ready: got aw=%b ar=%b expected 0/0", axa.awready, axa.arready); end
        @(posedge clk); #1;
        checks++; if (axa.bvalid !== 1'b0 || axa.rvalid !== 1'b0) begin fails++;
            $display("FAIL mid_rst_valid: got bvalid=%b rvalid=%b expected 0/0", axa.bvalid, axa.rvalid); end
        rst = 0;
        axa.awvalid = 0; axa.wvalid = 0; axa.arvalid = 0; axa.bready = 1; axa.rready = 1;
        repeat (8) begin @(negedge clk); if (axa.rvalid || axa.bvalid) stray++; end
        @(posedge clk); #1;
        checks++; if (stray != 0) begin fails++;
            $display("FAIL mid_stray: got %0d stray beats expected 0", stray); end
        a_read(32'h0000_0200, d, resp, lat);
        checks++; if (d !== 32'h0102_0304) begin fails++;
            $display("FAIL mid_no_write: got %h expected 01020304", d); end
    endtask

    task automatic test_fixed_priority();
        logic [1:0] resp; bit ok;
        b_write(32'h0000_0008, 32'h0BAD_CAFE, 4'hF, resp, ok);
        axb.awaddr = 32'h30; axb.wstrb = 4'hF; axb.araddr = 32'h8;
        axb.awvalid = 1; axb.wvalid = 1; axb.arvalid = 1; axb.bready = 1; axb.rready = 1;
        for (int k = 0; k < 4; k++) begin
            axb.wdata = 32'h100 + k;
            @(negedge clk);
            checks++; if (axb.awready !== 1'b1 || axb.arready !== 1'b0) begin fails++;
                $display("FAIL fixed_prio[%0d]: got aw=%b ar=%b expected 1/0", k, axb.awready, axb.arready); end
            @(posedge clk); #1;
        end
        axb.awvalid = 0; axb.wvalid = 0;
        @(negedge clk);
        checks++; if (axb.arready !== 1'b1) begin fails++;
            $display("FAIL fixed_read_after: got %b expected 1", axb.arready); end
        @(posedge clk); #1;
        axb.arvalid = 0;
        @(negedge clk);
        checks++; if (axb.rvalid !== 1'b1 || axb.rdata !== 32'h0BAD_CAFE) begin fails++;
            $display("FAIL fixed_lat1: got rvalid=%b rdata=%h expected 1/0badcafe", axb.rvalid, axb.rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_alias();
        logic [1:0] resp; logic [31:0] d; bit ok; int lat;
        b_write(32'h0001_0008, 32'h5A5A_0000, 4'hF, resp, ok);
        checks++; if (!ok || resp !== RESP_OKAY) begin fails++;
            $display("FAIL alias_bresp: got ok=%0d bresp=%b expected 1/00", ok, resp); end
        b_read(32'h0000_0008, d, resp, lat);
        checks++; if (d !== 32'h5A5A_0000 || resp !== RESP_OKAY || lat !== 1) begin fails++;
            $display("FAIL alias_low: got %h/%b lat %0d expected 5a5a0000/00 lat 1", d, resp, lat); end
        b_read(32'h0003_0008, d, resp, lat);
        checks++; if (d !== 32'h5A5A_0000 || resp !== RESP_OKAY) begin fails++;
            $display("FAIL alias_high: got %h/%b expected 5a5a0000/00", d, resp); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_strobe();
        test_addr_check();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_fixed_priority();
        test_alias();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
